// File: rtl/key_bounce_gen.sv
// Push-button emulator: turns clean press/release commands into a bouncy key level.
// Define KEY_BOUNCE_DETERMINISTIC_EN to fix every bounce gap at MAX_GAP cycles.
module key_bounce_gen #(
    parameter int unsigned BOUNCE_TOGGLES = 4,
    parameter int unsigned MAX_GAP        = 3,
    parameter int unsigned SETTLE_CYCLES  = 5,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_press,
    output logic cmd_ready,
    output logic key_out,
    output logic key_clean,
    output logic done
);

    localparam int unsigned EW = $clog2(2 * BOUNCE_TOGGLES + 2);
    localparam int unsigned GW = $clog2(MAX_GAP + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [EW-1:0] EDGES_INIT  = EW'(2 * BOUNCE_TOGGLES);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
    localparam logic [15:0]   SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t        state_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic [EW-1:0] edges_q;
    logic [SW-1:0] settle_q;
    logic          key_out_q;
    logic          key_clean_q;
    logic          done_q;
    logic          cmd_ready_q;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

`ifdef KEY_BOUNCE_DETERMINISTIC_EN
    always_comb begin
        gap_d = GW'(MAX_GAP);
    end
`else
    always_comb begin
        gap_d = GW'((32'(lfsr_q[GW-1:0]) % MAX_GAP) + 32'd1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            gap_q       <= '0;
            edges_q     <= '0;
            settle_q    <= '0;
            key_out_q   <= 1'b0;
            key_clean_q <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            lfsr_q <= lfsr_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_press == key_clean_q) begin
                            done_q <= 1'b1;
                        end else begin
                            key_clean_q <= cmd_press;
                            key_out_q   <= ~key_out_q;
                            edges_q     <= EDGES_INIT;
                            gap_q       <= gap_d;
                            cmd_ready_q <= 1'b0;
                            if (BOUNCE_TOGGLES == 0) begin
                                settle_q <= SETTLE_INIT;
                                state_q  <= SETTLE;
                            end else begin
                                state_q  <= BOUNCE;
                            end
                        end
                    end
                end
                BOUNCE: begin
                    // The edge fires on the cycle the counter sits at 1, so edges land exactly gap cycles apart.
                    if (gap_q <= GW'(1)) begin
                        key_out_q <= ~key_out_q;
                        edges_q   <= edges_q - EW'(1);
                        gap_q     <= gap_d;
                        if (edges_q == EW'(1)) begin
                            settle_q <= SETTLE_INIT;
                            state_q  <= SETTLE;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                SETTLE: begin
                    if (settle_q <= SW'(1)) begin
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        settle_q <= settle_q - SW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign key_out   = key_out_q;
    assign key_clean = key_clean_q;
    assign done      = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed and randomized checks of key_bounce_gen edge timing, handshake and reset.
module tb_key_bounce_gen;

`ifdef KEY_BOUNCE_DETERMINISTIC_EN
    localparam int DG = 3;
`else
    localparam int DG = 1;
`endif
    localparam int DONE_T = 1 + 4 * DG + 5;

    logic clk = 1'b0;
    logic rst_n;
    logic a_valid, a_press, a_ready, a_key, a_clean, a_done;
    logic b_valid, b_press, b_ready, b_key, b_clean, b_done;
    logic c_valid, c_press, c_ready, c_key, c_clean, c_done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    key_bounce_gen #(.BOUNCE_TOGGLES(2), .MAX_GAP(DG), .SETTLE_CYCLES(5), .LFSR_SEED(16'hACE1)) u_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_press(a_press),
        .cmd_ready(a_ready), .key_out(a_key), .key_clean(a_clean), .done(a_done));

    key_bounce_gen #(.BOUNCE_TOGGLES(0), .MAX_GAP(3), .SETTLE_CYCLES(5), .LFSR_SEED(16'hACE1)) u_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_press(b_press),
        .cmd_ready(b_ready), .key_out(b_key), .key_clean(b_clean), .done(b_done));

    key_bounce_gen #(.BOUNCE_TOGGLES(3), .MAX_GAP(3), .SETTLE_CYCLES(4), .LFSR_SEED(16'h1234)) u_c (
        .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid), .cmd_press(c_press),
        .cmd_ready(c_ready), .key_out(c_key), .key_clean(c_clean), .done(c_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Exact waveform of DUT A: edges at 1+k*DG (k=0..4), done at DONE_T.
    task automatic exact_cmd(input logic press, input logic init, input bit pre,
                             input bit hold, input int stop_at);
        int last_t;
        int n;
        last_t = (stop_at > 0) ? stop_at : DONE_T;
        if (!pre) begin
            a_press = press;
            a_valid = 1'b1;
        end
        tick;
        if (hold) a_press = ~press;
        else      a_valid = 1'b0;
        for (int t = 1; t <= last_t; t++) begin
            n = 0;
            for (int k = 0; k < 5; k++)
                if (1 + k * DG <= t) n++;
            check("ex_key",   32'(a_key),   32'(init ^ n[0]));
            check("ex_clean", 32'(a_clean), 32'(press));
            check("ex_done",  32'(a_done),  32'(t == DONE_T));
            check("ex_ready", 32'(a_ready), 32'(t >= DONE_T));
            if (t < last_t) tick;
        end
    endtask

    initial begin
        logic model_level;
        logic prev_key;
        logic p;
        int   t, edges, last, exp_edges;
        bit   gap_bad, ready_bad, done_seen;

        rst_n = 1'b0;
        a_valid = 1'b0; a_press = 1'b0;
        b_valid = 1'b0; b_press = 1'b0;
        c_valid = 1'b0; c_press = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        check("rst_key",   32'(a_key),   0);
        check("rst_clean", 32'(a_clean), 0);
        check("rst_ready", 32'(a_ready), 1);
        check("rst_done",  32'(a_done),  0);

        exact_cmd(1'b1, 1'b0, 1'b0, 1'b0, 0);
        exact_cmd(1'b0, 1'b1, 1'b0, 1'b0, 0);
        exact_cmd(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Press while already pressed: no edges, immediate done.
        a_press = 1'b1; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        check("same_done1",  32'(a_done),  1);
        check("same_ready1", 32'(a_ready), 1);
        check("same_key1",   32'(a_key),   1);
        tick;
        check("same_done2",  32'(a_done),  0);
        check("same_ready2", 32'(a_ready), 1);
        check("same_key2",   32'(a_key),   1);

        // Release with an opposite press held on cmd_valid throughout the bounce.
        exact_cmd(1'b0, 1'b1, 1'b0, 1'b1, 0);
        exact_cmd(1'b1, 1'b0, 1'b1, 1'b0, 0);
        exact_cmd(1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Reset in the middle of a press, then replay.
        exact_cmd(1'b1, 1'b0, 1'b0, 1'b0, 6);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("mid_rst_key",   32'(a_key),   0);
        check("mid_rst_clean", 32'(a_clean), 0);
        check("mid_rst_ready", 32'(a_ready), 1);
        check("mid_rst_done",  32'(a_done),  0);
        exact_cmd(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Zero bounce toggles: one clean edge, done five cycles later.
        b_press = 1'b1; b_valid = 1'b1;
        tick;
        b_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            check("nb_key",   32'(b_key),   1);
            check("nb_clean", 32'(b_clean), 1);
            check("nb_done",  32'(b_done),  32'(i == 6));
            check("nb_ready", 32'(b_ready), 32'(i == 6));
            if (i < 6) tick;
        end

        // Random commands on the LFSR-timed instance.
        model_level = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            p = 1'($urandom_range(0, 1));
            prev_key = model_level;
            exp_edges = (p != model_level) ? 7 : 0;
            c_press = p; c_valid = 1'b1;
            tick;
            c_valid = 1'b0;
            t = 1; edges = 0; last = 0;
            gap_bad = 1'b0; ready_bad = 1'b0; done_seen = 1'b0;
            while (!done_seen && t < 200) begin
                if (c_key != prev_key) begin
                    if (edges > 0 && (t - last < 1 || t - last > 3)) gap_bad = 1'b1;
                    edges++;
                    last = t;
                    prev_key = c_key;
                end
                if (c_done) done_seen = 1'b1;
                else begin
                    if (c_ready) ready_bad = 1'b1;
                    tick;
                    t++;
                end
            end
            check("rnd_done_seen", 32'(done_seen), 1);
            check("rnd_edges",     32'(edges),     32'(exp_edges));
            check("rnd_gap_range", 32'(gap_bad),   0);
            check("rnd_ready_low", 32'(ready_bad), 0);
            check("rnd_key",       32'(c_key),     32'(p));
            check("rnd_clean",     32'(c_clean),   32'(p));
            if (edges > 0) check("rnd_settle", 32'(t - last), 4);
            else           check("rnd_same_t", 32'(t), 1);
            model_level = p;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
